spi_display_sink: RTL and testbench
===================================

SPI_DISPLAY_SINK -- requirements
Module: spi_display_sink

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on every SPI input.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 spi_clk  input  1  serial clock, idle low, asynchronous to clk.
REQ-005 spi_din  input  1  serial data, MSB first.
REQ-006 spi_cs  input  1  chip select, active-low.
REQ-007 spi_dc  input  1  0 = command byte, 1 = data byte.
REQ-008 spi_rst  input  1  display reset, active-low.
REQ-009 byte_out  output  8  last received byte.
REQ-010 byte_dc  output  1  spi_dc value captured with byte_out.
REQ-011 byte_valid  output  1  one-cycle strobe, byte_out/byte_dc new.
REQ-012 display_on  output  1  state set by 0xAE/0xAF.
REQ-013 contrast  output  8  argument of 0x81.
REQ-014 precharge  output  8  argument of 0xD9.
REQ-015 charge_pump_on  output  1  bit 2 of 0x8D argument.
REQ-016 all_on  output  1  0xA4 clears, 0xA5 sets.
REQ-017 inverted  output  1  0xA6 clears, 0xA7 sets.
REQ-018 cmd_error  output  1  one-cycle strobe on unrecognised command opcode.

Function
REQ-019 All SPI inputs SHALL pass through SYNC_STAGES flops before use; every rule below applies to synchronized values.
REQ-020 A spi_clk rising edge SHALL be detected as synchronized value 1 while the previous synchronized value was 0; spi_din and spi_dc are sampled in that same cycle.
REQ-021 Edges are only counted while synchronized spi_cs = 0; a 3-bit bit counter SHALL shift spi_din into an 8-bit shift register MSB first.
REQ-022 On the 8th counted edge the block SHALL, in the next clk cycle, drive byte_out, byte_dc and a one-cycle byte_valid = 1, and clear the bit counter.
REQ-023 spi_cs = 1 SHALL clear the bit counter and discard any partial byte without asserting byte_valid; decoder state is kept.
REQ-024 Supported spi_clk: high and low phases each >= SYNC_STAGES+1 clk cycles; faster input is undefined.
REQ-025 Command decoder FSM states: IDLE, ARG; only bytes with byte_dc = 0 are decoded.
REQ-026 IDLE: 0xAE/0xAF, 0xA4/0xA5, 0xA6/0xA7 update their output in the cycle after byte_valid and stay IDLE.
REQ-027 IDLE: 0x81, 0xD9, 0x8D SHALL latch the opcode as pending and move to ARG.
REQ-028 IDLE: any other opcode SHALL pulse cmd_error one cycle (coincident with the update slot of REQ-026) and change nothing else.
REQ-029 ARG: next command byte SHALL be written to the register of the pending opcode (charge_pump_on = bit 2), then return to IDLE.
REQ-030 ARG: a data byte (byte_dc = 1) SHALL abandon the pending opcode, leave all registers unchanged, and return to IDLE; byte_valid still pulses.
REQ-031 Data bytes in IDLE SHALL only produce byte_valid; no register changes.
REQ-032 Synchronized spi_rst = 0 SHALL, synchronously, force all decoded registers to defaults, FSM to IDLE, bit counter to 0, and suppress byte_valid/cmd_error for as long as it is low.

Reset
REQ-033 While rst = 1 asynchronously: byte_out = 0x00, byte_dc = 0, byte_valid = 0, cmd_error = 0, FSM = IDLE, bit counter = 0, synchronizers = (spi_cs 1, spi_rst 1, others 0).
REQ-034 Decoded defaults (rst and spi_rst): display_on = 0, contrast = 0x7F, precharge = 0x22, charge_pump_on = 0, all_on = 0, inverted = 0.
REQ-035 rst released mid-byte SHALL start reception from bit 0 at the next counted edge.

Verification
REQ-036 Command bytes AE,8D,14,81,70,D9,F1,A4,A6,AF with spi_clk half period 11 clk -> 10 byte_valid pulses, byte_dc = 0; final display_on = 1, contrast = 0x70, precharge = 0xF1, charge_pump_on = 1, all_on = 0, inverted = 0, no cmd_error.
REQ-037 5 bits of 0xFF, spi_cs high, then full 0xA7 -> exactly one byte_valid, byte_out = 0xA7, inverted = 1.
REQ-038 Command 0x42 -> one cmd_error pulse, all decoded outputs unchanged, FSM IDLE.
REQ-039 Command 0x81 then data byte 0x55 (dc = 1) then command 0xAF -> contrast stays 0x7F, byte_out = 0x55 with byte_dc = 1, then display_on = 1.
REQ-040 After REQ-036 sequence, pull spi_rst low 20 clk -> all decoded outputs at REQ-034 defaults; bytes sent during low produce no byte_valid.
REQ-041 Assert rst for 1 clk after 3 bits of a byte, then send 0xAF -> one byte_valid with 0xAF, display_on = 1.

Source files
------------

// File: rtl/spi_display_sink.sv
// SPI sink for an SSD1306-style display: resynchronises the serial port, assembles bytes
// and decodes the small command set that drives display state registers.
module spi_display_sink #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_din,
    input  logic       spi_cs,
    input  logic       spi_dc,
    input  logic       spi_rst,
    output logic [7:0] byte_out,
    output logic       byte_dc,
    output logic       byte_valid,
    output logic       display_on,
    output logic [7:0] contrast,
    output logic [7:0] precharge,
    output logic       charge_pump_on,
    output logic       all_on,
    output logic       inverted,
    output logic       cmd_error
);

    typedef enum logic {
        ST_IDLE,
        ST_ARG
    } state_t;

    // Bundle order {spi_rst, spi_cs, spi_dc, spi_din, spi_clk}; the two selects idle high.
    localparam logic [4:0] SYNC_RST = 5'b11000;

    logic [4:0] sync_q [SYNC_STAGES];
    logic       sclk_s, din_s, dc_s, cs_s, srst_s;
    logic       sclk_prev;
    logic       sclk_rise;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;

    state_t     state, state_nxt;
    logic [7:0] pending, pending_nxt;
    logic       display_on_nxt, charge_pump_on_nxt, all_on_nxt, inverted_nxt, cmd_error_nxt;
    logic [7:0] contrast_nxt, precharge_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
        end else begin
            sync_q[0] <= {spi_rst, spi_cs, spi_dc, spi_din, spi_clk};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {srst_s, cs_s, dc_s, din_s, sclk_s} = sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev  <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_out   <= '0;
            byte_dc    <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            sclk_prev  <= sclk_s;
            byte_valid <= 1'b0;
            if (!srst_s || cs_s) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], din_s};
                bit_cnt <= bit_cnt + 3'd1;
                // counter wraps to zero on the eighth bit, ready for the next byte
                if (bit_cnt == 3'd7) begin
                    byte_out   <= {shreg, din_s};
                    byte_dc    <= dc_s;
                    byte_valid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            pending        <= '0;
            display_on     <= 1'b0;
            contrast       <= 8'h7F;
            precharge      <= 8'h22;
            charge_pump_on <= 1'b0;
            all_on         <= 1'b0;
            inverted       <= 1'b0;
            cmd_error      <= 1'b0;
        end else begin
            state          <= state_nxt;
            pending        <= pending_nxt;
            display_on     <= display_on_nxt;
            contrast       <= contrast_nxt;
            precharge      <= precharge_nxt;
            charge_pump_on <= charge_pump_on_nxt;
            all_on         <= all_on_nxt;
            inverted       <= inverted_nxt;
            cmd_error      <= cmd_error_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        pending_nxt        = pending;
        display_on_nxt     = display_on;
        contrast_nxt       = contrast;
        precharge_nxt      = precharge;
        charge_pump_on_nxt = charge_pump_on;
        all_on_nxt         = all_on;
        inverted_nxt       = inverted;
        cmd_error_nxt      = 1'b0;
        if (!srst_s) begin
            state_nxt          = ST_IDLE;
            display_on_nxt     = 1'b0;
            contrast_nxt       = 8'h7F;
            precharge_nxt      = 8'h22;
            charge_pump_on_nxt = 1'b0;
            all_on_nxt         = 1'b0;
            inverted_nxt       = 1'b0;
        end else if (byte_valid) begin
            case (state)
                ST_IDLE: begin
                    if (!byte_dc) begin
                        case (byte_out)
                            8'hAE: display_on_nxt = 1'b0;
                            8'hAF: display_on_nxt = 1'b1;
                            8'hA4: all_on_nxt     = 1'b0;
                            8'hA5: all_on_nxt     = 1'b1;
                            8'hA6: inverted_nxt   = 1'b0;
                            8'hA7: inverted_nxt   = 1'b1;
                            8'h81, 8'hD9, 8'h8D: begin
                                pending_nxt = byte_out;
                                state_nxt   = ST_ARG;
                            end
                            default: cmd_error_nxt = 1'b1;
                        endcase
                    end
                end
                ST_ARG: begin
                    // a data byte here drops the pending command without touching registers
                    state_nxt = ST_IDLE;
                    if (!byte_dc) begin
                        case (pending)
                            8'h81:   contrast_nxt       = byte_out;
                            8'hD9:   precharge_nxt      = byte_out;
                            8'h8D:   charge_pump_on_nxt = byte_out[2];
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_display_sink.sv
// Directed bench for spi_display_sink: bit-banged SPI bytes, hand-computed expected registers.
`timescale 1ns/1ps
module tb_spi_display_sink;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spi_clk = 1'b0;
    logic       spi_din = 1'b0;
    logic       spi_cs = 1'b1;
    logic       spi_dc = 1'b0;
    logic       spi_rst = 1'b1;
    logic [7:0] byte_out;
    logic       byte_dc;
    logic       byte_valid;
    logic       display_on;
    logic [7:0] contrast;
    logic [7:0] precharge;
    logic       charge_pump_on;
    logic       all_on;
    logic       inverted;
    logic       cmd_error;

    int total = 0;
    int bad = 0;
    int vcnt = 0;
    int vdc = 0;
    int ecnt = 0;
    int v0, d0, e0;

    spi_display_sink #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .spi_clk(spi_clk), .spi_din(spi_din), .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_rst(spi_rst),
        .byte_out(byte_out), .byte_dc(byte_dc), .byte_valid(byte_valid),
        .display_on(display_on), .contrast(contrast), .precharge(precharge),
        .charge_pump_on(charge_pump_on), .all_on(all_on), .inverted(inverted),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    // Counts strobe cycles; a one-cycle strobe makes cycles equal pulses.
    always @(negedge clk) begin
        if (byte_valid) begin
            vcnt++;
            if (byte_dc) vdc++;
        end
        if (cmd_error) ecnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        spi_din = b;
        clks(11);
        spi_clk = 1'b1;
        clks(11);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic dc);
        @(negedge clk);
        spi_cs = 1'b0;
        spi_dc = dc;
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        clks(11);
        spi_cs = 1'b1;
        clks(6);
    endtask

    task automatic snap();
        v0 = vcnt;
        d0 = vdc;
        e0 = ecnt;
    endtask

    logic [7:0] init_seq [10];
    logic [7:0] partial;

    initial begin
        init_seq = '{8'hAE, 8'h8D, 8'h14, 8'h81, 8'h70, 8'hD9, 8'hF1, 8'hA4, 8'hA6, 8'hAF};

        // reset state
        clks(5);
        check("rst byte_out", byte_out, 8'h00);
        check("rst byte_dc", {7'd0, byte_dc}, 8'h00);
        check("rst byte_valid", {7'd0, byte_valid}, 8'h00);
        check("rst cmd_error", {7'd0, cmd_error}, 8'h00);
        check("rst display_on", {7'd0, display_on}, 8'h00);
        check("rst contrast", contrast, 8'h7F);
        check("rst precharge", precharge, 8'h22);
        check("rst charge_pump", {7'd0, charge_pump_on}, 8'h00);
        check("rst all_on", {7'd0, all_on}, 8'h00);
        check("rst inverted", {7'd0, inverted}, 8'h00);
        rst = 1'b0;
        clks(5);

        // init sequence
        snap();
        for (int i = 0; i < 10; i++) send_byte(init_seq[i], 1'b0);
        check("init valid count", 8'(vcnt - v0), 8'd10);
        check("init dc count", 8'(vdc - d0), 8'd0);
        check("init error count", 8'(ecnt - e0), 8'd0);
        check("init byte_out", byte_out, 8'hAF);
        check("init display_on", {7'd0, display_on}, 8'h01);
        check("init contrast", contrast, 8'h70);
        check("init precharge", precharge, 8'hF1);
        check("init charge_pump", {7'd0, charge_pump_on}, 8'h01);
        check("init all_on", {7'd0, all_on}, 8'h00);
        check("init inverted", {7'd0, inverted}, 8'h00);

        // display reset held low
        @(negedge clk);
        spi_rst = 1'b0;
        clks(20);
        check("srst display_on", {7'd0, display_on}, 8'h00);
        check("srst contrast", contrast, 8'h7F);
        check("srst precharge", precharge, 8'h22);
        check("srst charge_pump", {7'd0, charge_pump_on}, 8'h00);
        check("srst all_on", {7'd0, all_on}, 8'h00);
        check("srst inverted", {7'd0, inverted}, 8'h00);
        snap();
        send_byte(8'hAF, 1'b0);
        send_byte(8'hA5, 1'b0);
        check("srst valid count", 8'(vcnt - v0), 8'd0);
        check("srst error count", 8'(ecnt - e0), 8'd0);
        check("srst display_on held", {7'd0, display_on}, 8'h00);
        check("srst all_on held", {7'd0, all_on}, 8'h00);
        spi_rst = 1'b1;
        clks(6);

        // pending argument abandoned by a data byte
        snap();
        send_byte(8'h81, 1'b0);
        send_byte(8'h55, 1'b1);
        check("abandon byte_out", byte_out, 8'h55);
        check("abandon byte_dc", {7'd0, byte_dc}, 8'h01);
        check("abandon contrast", contrast, 8'h7F);
        send_byte(8'hAF, 1'b0);
        check("abandon display_on", {7'd0, display_on}, 8'h01);
        check("abandon contrast after", contrast, 8'h7F);
        check("abandon valid count", 8'(vcnt - v0), 8'd3);
        check("abandon dc count", 8'(vdc - d0), 8'd1);

        // partial byte discarded by chip select
        snap();
        @(negedge clk);
        spi_cs = 1'b0;
        spi_dc = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        clks(11);
        spi_cs = 1'b1;
        clks(11);
        check("partial no valid", 8'(vcnt - v0), 8'd0);
        send_byte(8'hA7, 1'b0);
        check("partial valid count", 8'(vcnt - v0), 8'd1);
        check("partial byte_out", byte_out, 8'hA7);
        check("partial inverted", {7'd0, inverted}, 8'h01);

        // unknown opcode
        snap();
        send_byte(8'h42, 1'b0);
        check("badcmd error count", 8'(ecnt - e0), 8'd1);
        check("badcmd display_on", {7'd0, display_on}, 8'h01);
        check("badcmd contrast", contrast, 8'h7F);
        check("badcmd precharge", precharge, 8'h22);
        check("badcmd inverted", {7'd0, inverted}, 8'h01);
        send_byte(8'hA6, 1'b0);
        check("badcmd idle after", {7'd0, inverted}, 8'h00);
        check("badcmd contrast after", contrast, 8'h7F);

        // system reset mid-byte, then a full byte in the same frame
        snap();
        partial = 8'hA0;
        @(negedge clk);
        spi_cs = 1'b0;
        spi_dc = 1'b0;
        for (int i = 7; i >= 5; i--) send_bit(partial[i]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst display_on", {7'd0, display_on}, 8'h00);
        check("midrst byte_out", byte_out, 8'h00);
        partial = 8'hAF;
        for (int i = 7; i >= 0; i--) send_bit(partial[i]);
        clks(11);
        spi_cs = 1'b1;
        clks(6);
        check("midrst valid count", 8'(vcnt - v0), 8'd1);
        check("midrst byte_out after", byte_out, 8'hAF);
        check("midrst display_on after", {7'd0, display_on}, 8'h01);
        check("midrst error count", 8'(ecnt - e0), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
